// File: rtl/exc_ctrl_pkg.sv
// Shared exception definitions: cause codes, CP0 addresses and Status bit positions,
// exception vectors and the default flush length.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_CAUSE_INT     = 5'h00;
    localparam logic [4:0] EXC_CAUSE_ADEL    = 5'h04;
    localparam logic [4:0] EXC_CAUSE_ADES    = 5'h05;
    localparam logic [4:0] EXC_CAUSE_SYSCALL = 5'h08;
    localparam logic [4:0] EXC_CAUSE_BP      = 5'h09;
    localparam logic [4:0] EXC_CAUSE_RI      = 5'h0a;
    localparam logic [4:0] EXC_CAUSE_OV      = 5'h0c;
    localparam logic [4:0] EXC_CAUSE_NOP     = 5'h1f;

    localparam logic [4:0] CP0_ADDR_EPC = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 10;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV   = 22;

    localparam logic [31:0] EXC_VECTOR     = 32'h8000_0180;
    localparam logic [31:0] EXC_VECTOR_BEV = 32'hBFC0_0380;

    localparam int EXC_FLUSH_CYCLES = 2;

    function automatic logic [31:0] exc_vector(input logic bev);
        return bev ? EXC_VECTOR_BEV : EXC_VECTOR;
    endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Purpose: picks the single highest-priority event among interrupt, stage causes and ERET.
// Latency: combinational. Backpressure: none; the caller only samples it while idle.
module exc_prio_sel
    import exc_ctrl_pkg::*;
(
    input  logic        i_int_pending,
    input  logic        i_mem_valid,
    input  logic        i_mem_eret,
    input  logic [4:0]  i_if_cause,
    input  logic [4:0]  i_id_cause,
    input  logic [4:0]  i_ex_cause,
    input  logic [4:0]  i_mem_cause,
    input  logic [31:0] i_if_pc,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_mem_pc,
    input  logic        i_if_bd,
    input  logic        i_id_bd,
    input  logic        i_ex_bd,
    input  logic        i_mem_bd,
    output logic        o_valid,
    output logic [4:0]  o_cause,
    output logic [31:0] o_pc,
    output logic        o_bd,
    output logic        o_is_eret
);

    always_comb begin
        o_valid   = 1'b0;
        o_cause   = EXC_CAUSE_NOP;
        o_pc      = i_mem_pc;
        o_bd      = i_mem_bd;
        o_is_eret = 1'b0;
        // Interrupts need a real instruction in MEM to attach an EPC to.
        if (i_int_pending && i_mem_valid) begin
            o_valid = 1'b1;
            o_cause = EXC_CAUSE_INT;
        end else if (i_mem_cause != EXC_CAUSE_NOP) begin
            o_valid = 1'b1;
            o_cause = i_mem_cause;
        end else if (i_ex_cause != EXC_CAUSE_NOP) begin
            o_valid = 1'b1;
            o_cause = i_ex_cause;
            o_pc    = i_ex_pc;
            o_bd    = i_ex_bd;
        end else if (i_id_cause != EXC_CAUSE_NOP) begin
            o_valid = 1'b1;
            o_cause = i_id_cause;
            o_pc    = i_id_pc;
            o_bd    = i_id_bd;
        end else if (i_if_cause != EXC_CAUSE_NOP) begin
            o_valid = 1'b1;
            o_cause = i_if_cause;
            o_pc    = i_if_pc;
            o_bd    = i_if_bd;
        end else if (i_mem_eret) begin
            o_valid   = 1'b1;
            o_is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Purpose: sequences one exception/interrupt/ERET at a time into CP0 entry, pipeline flush and fetch redirect.
// Latency: event in cycle N -> CP0 inputs N+1, flush N+1..N+FLUSH_CYCLES, redirect N+FLUSH_CYCLES+1.
// Backpressure: redirect holds valid and pc until i_redirect_ready; no new event is taken until then.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = EXC_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  i_if_cause,
    input  logic [4:0]  i_id_cause,
    input  logic [4:0]  i_ex_cause,
    input  logic [4:0]  i_mem_cause,
    input  logic [31:0] i_if_pc,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_mem_pc,
    input  logic        i_if_bd,
    input  logic        i_id_bd,
    input  logic        i_ex_bd,
    input  logic        i_mem_bd,
    input  logic        i_mem_valid,
    input  logic        i_mem_eret,
    input  logic [5:0]  i_int,
    input  logic [31:0] i_status,
    input  logic [31:0] i_epc,
    input  logic        i_cp0_we,
    input  logic [4:0]  i_cp0_waddr,
    input  logic [31:0] i_cp0_wdata,
    output logic [4:0]  o_except_cause,
    output logic [31:0] o_exc_pc,
    output logic        o_exc_bd,
    output logic        o_is_eret,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  int_meta_q, int_meta_d;
    logic [5:0]  int_s_q, int_s_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_bd_q, exc_bd_d;
    logic        is_eret_q, is_eret_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic        busy_q, busy_d;

    logic        int_pending;
    logic        sel_valid;
    logic [4:0]  sel_cause;
    logic [31:0] sel_pc;
    logic        sel_bd;
    logic        sel_is_eret;
    logic [31:0] epc_fwd;
    logic        unused_status;

    assign int_pending = (|(int_s_q & i_status[STATUS_IM_HI:STATUS_IM_LO]))
                       & i_status[STATUS_IE] & ~i_status[STATUS_EXL];
    // An MTC0 to EPC in the same cycle as ERET must win over the stale register value.
    assign epc_fwd = (i_cp0_we && i_cp0_waddr == CP0_ADDR_EPC) ? i_cp0_wdata : i_epc;
    assign unused_status = ^{i_status[31:23], i_status[21:16], i_status[9:2]};

    exc_prio_sel u_prio_sel (
        .i_int_pending (int_pending),
        .i_mem_valid   (i_mem_valid),
        .i_mem_eret    (i_mem_eret),
        .i_if_cause    (i_if_cause),
        .i_id_cause    (i_id_cause),
        .i_ex_cause    (i_ex_cause),
        .i_mem_cause   (i_mem_cause),
        .i_if_pc       (i_if_pc),
        .i_id_pc       (i_id_pc),
        .i_ex_pc       (i_ex_pc),
        .i_mem_pc      (i_mem_pc),
        .i_if_bd       (i_if_bd),
        .i_id_bd       (i_id_bd),
        .i_ex_bd       (i_ex_bd),
        .i_mem_bd      (i_mem_bd),
        .o_valid       (sel_valid),
        .o_cause       (sel_cause),
        .o_pc          (sel_pc),
        .o_bd          (sel_bd),
        .o_is_eret     (sel_is_eret)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        int_meta_d = i_int;
        int_s_d    = int_meta_q;
        cause_d    = EXC_CAUSE_NOP;
        exc_pc_d   = exc_pc_q;
        exc_bd_d   = exc_bd_q;
        is_eret_d  = 1'b0;
        flush_d    = 1'b0;
        rv_d       = 1'b0;
        rpc_d      = rpc_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = COMMIT;
                    flush_d = 1'b1;
                    if (sel_is_eret) begin
                        is_eret_d = 1'b1;
                        rpc_d     = epc_fwd;
                    end else begin
                        cause_d  = sel_cause;
                        exc_pc_d = sel_pc;
                        exc_bd_d = sel_bd;
                        rpc_d    = exc_vector(i_status[STATUS_BEV]);
                    end
                end
            end
            COMMIT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = 4'd0;
                    flush_d = 1'b1;
                end else begin
                    state_d = REDIRECT;
                    rv_d    = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = REDIRECT;
                    cnt_d   = 4'd0;
                    rv_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    flush_d = 1'b1;
                end
            end
            REDIRECT: begin
                if (i_redirect_ready) state_d = IDLE;
                else                  rv_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            int_meta_q <= 6'd0;
            int_s_q    <= 6'd0;
            cause_q    <= EXC_CAUSE_NOP;
            exc_pc_q   <= 32'd0;
            exc_bd_q   <= 1'b0;
            is_eret_q  <= 1'b0;
            flush_q    <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_meta_q <= int_meta_d;
            int_s_q    <= int_s_d;
            cause_q    <= cause_d;
            exc_pc_q   <= exc_pc_d;
            exc_bd_q   <= exc_bd_d;
            is_eret_q  <= is_eret_d;
            flush_q    <= flush_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            busy_q     <= busy_d;
        end
    end

    assign o_except_cause   = cause_q;
    assign o_exc_pc         = exc_pc_q;
    assign o_exc_bd         = exc_bd_q;
    assign o_is_eret        = is_eret_q;
    assign o_flush          = flush_q;
    assign o_redirect_valid = rv_q;
    assign o_redirect_pc    = rpc_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: expected CP0-entry records are queued when an event is driven
// and popped when the DUT shows its COMMIT cycle.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic        clk, resetn;
    logic [4:0]  i_if_cause, i_id_cause, i_ex_cause, i_mem_cause;
    logic [31:0] i_if_pc, i_id_pc, i_ex_pc, i_mem_pc;
    logic        i_if_bd, i_id_bd, i_ex_bd, i_mem_bd;
    logic        i_mem_valid, i_mem_eret;
    logic [5:0]  i_int;
    logic [31:0] i_status, i_epc;
    logic        i_cp0_we;
    logic [4:0]  i_cp0_waddr;
    logic [31:0] i_cp0_wdata;
    logic [4:0]  o_except_cause;
    logic [31:0] o_exc_pc;
    logic        o_exc_bd, o_is_eret, o_flush, o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_redirect_ready;
    logic        o_busy;

    typedef struct {
        logic [4:0]  cause;
        logic [31:0] pc;
        logic        bd;
        logic        eret;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    exc_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_if_cause       (i_if_cause),
        .i_id_cause       (i_id_cause),
        .i_ex_cause       (i_ex_cause),
        .i_mem_cause      (i_mem_cause),
        .i_if_pc          (i_if_pc),
        .i_id_pc          (i_id_pc),
        .i_ex_pc          (i_ex_pc),
        .i_mem_pc         (i_mem_pc),
        .i_if_bd          (i_if_bd),
        .i_id_bd          (i_id_bd),
        .i_ex_bd          (i_ex_bd),
        .i_mem_bd         (i_mem_bd),
        .i_mem_valid      (i_mem_valid),
        .i_mem_eret       (i_mem_eret),
        .i_int            (i_int),
        .i_status         (i_status),
        .i_epc            (i_epc),
        .i_cp0_we         (i_cp0_we),
        .i_cp0_waddr      (i_cp0_waddr),
        .i_cp0_wdata      (i_cp0_wdata),
        .o_except_cause   (o_except_cause),
        .o_exc_pc         (o_exc_pc),
        .o_exc_bd         (o_exc_bd),
        .o_is_eret        (o_is_eret),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .i_redirect_ready (i_redirect_ready),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_if_cause  = EXC_CAUSE_NOP; i_id_cause = EXC_CAUSE_NOP;
        i_ex_cause  = EXC_CAUSE_NOP; i_mem_cause = EXC_CAUSE_NOP;
        i_if_pc     = 32'd0; i_id_pc = 32'd0; i_ex_pc = 32'd0; i_mem_pc = 32'd0;
        i_if_bd     = 1'b0; i_id_bd = 1'b0; i_ex_bd = 1'b0; i_mem_bd = 1'b0;
        i_mem_valid = 1'b0; i_mem_eret = 1'b0; i_int = 6'd0;
        i_cp0_we    = 1'b0; i_cp0_waddr = 5'd0; i_cp0_wdata = 32'd0;
    endtask

    // Steps until redirect valid, counting flush cycles including the current (COMMIT) one.
    task automatic wait_redirect(input int budget, output int flush_cnt, output bit seen);
        flush_cnt = (o_flush === 1'b1) ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (o_redirect_valid === 1'b1) seen = 1'b1;
            else if (o_flush === 1'b1) flush_cnt++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret} !== {EXC_CAUSE_NOP, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_cp0_outs: got cause=%h pc=%h bd=%b eret=%b", o_except_cause, o_exc_pc, o_exc_bd, o_is_eret);
        else n_pass++;
        n_checks++;
        if ({o_flush, o_redirect_valid, o_redirect_pc, o_busy} !== {1'b0, 1'b0, 32'd0, 1'b0})
            $display("FAIL reset_ctrl_outs: got flush=%b rv=%b rpc=%h busy=%b", o_flush, o_redirect_valid, o_redirect_pc, o_busy);
        else n_pass++;
        resetn = 1'b1;
        repeat (2) step();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_syscall();
        int fc; bit seen;
        i_status = 32'h0; i_redirect_ready = 1'b0;
        i_ex_cause = EXC_CAUSE_SYSCALL; i_ex_pc = 32'h8000_1000; i_ex_bd = 1'b0;
        exp_q.push_back('{EXC_CAUSE_SYSCALL, 32'h8000_1000, 1'b0, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret, o_flush, o_busy} !== {e.cause, e.pc, e.bd, e.eret, 1'b1, 1'b1})
            $display("FAIL syscall_commit: got cause=%h pc=%h bd=%b eret=%b flush=%b busy=%b want cause=%h pc=%h",
                     o_except_cause, o_exc_pc, o_exc_bd, o_is_eret, o_flush, o_busy, e.cause, e.pc);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || fc != 2) $display("FAIL syscall_flush: seen=%b flush_cycles=%0d want 2", seen, fc);
        else n_pass++;
        n_checks++;
        if (o_redirect_pc !== e.tgt || o_except_cause !== EXC_CAUSE_NOP)
            $display("FAIL syscall_target: got rpc=%h cause=%h want rpc=%h", o_redirect_pc, o_except_cause, e.tgt);
        else n_pass++;
        step();
        n_checks++;
        if (o_redirect_valid !== 1'b1 || o_redirect_pc !== e.tgt)
            $display("FAIL syscall_hold: rv=%b rpc=%h want 1 %h", o_redirect_valid, o_redirect_pc, e.tgt);
        else n_pass++;
        i_redirect_ready = 1'b1;
        step();
        n_checks++;
        if (o_redirect_valid !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL syscall_done: rv=%b busy=%b want 0 0", o_redirect_valid, o_busy);
        else n_pass++;
    endtask

    task automatic test_int_exl_latency();
        int fc; bit seen;
        // EXL set: interrupt masked no matter how long it is held.
        i_status = 32'h0000_FF03; i_int = 6'b000100;
        i_mem_valid = 1'b1; i_mem_pc = 32'h8000_1100;
        repeat (6) step();
        n_checks++;
        if (o_busy !== 1'b0 || o_except_cause !== EXC_CAUSE_NOP)
            $display("FAIL int_exl_masked: busy=%b cause=%h want 0 %h", o_busy, o_except_cause, EXC_CAUSE_NOP);
        else n_pass++;
        i_int = 6'd0;
        repeat (3) step();
        i_status = 32'h0000_FF01; i_int = 6'b000100;
        exp_q.push_back('{EXC_CAUSE_INT, 32'h8000_1100, 1'b0, 1'b0, EXC_VECTOR});
        repeat (2) step();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL int_latency_early: busy=%b want 0 after 2 cycles", o_busy);
        else n_pass++;
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd} !== {e.cause, e.pc, e.bd})
            $display("FAIL int_latency_commit: got cause=%h pc=%h bd=%b want %h %h %b",
                     o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        i_redirect_ready = 1'b1;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || o_redirect_pc !== e.tgt) $display("FAIL int_latency_target: seen=%b rpc=%h want %h", seen, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
    endtask

    task automatic test_int_vs_id();
        int fc; bit seen;
        i_status = 32'h0000_FF01; i_int = 6'b000100; i_mem_valid = 1'b0;
        repeat (4) step();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL int_wait_mem_valid: busy=%b want 0", o_busy);
        else n_pass++;
        i_mem_valid = 1'b1; i_mem_pc = 32'h8000_2004; i_mem_bd = 1'b1;
        i_id_cause = EXC_CAUSE_RI; i_id_pc = 32'h8000_2000; i_id_bd = 1'b0;
        exp_q.push_back('{EXC_CAUSE_INT, 32'h8000_2004, 1'b1, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret} !== {e.cause, e.pc, e.bd, e.eret})
            $display("FAIL int_vs_id_commit: got cause=%h pc=%h bd=%b want %h %h %b",
                     o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || o_redirect_pc !== e.tgt) $display("FAIL int_vs_id_target: seen=%b rpc=%h want %h", seen, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
    endtask

    task automatic test_eret();
        int fc; bit seen;
        i_status = 32'h0; i_redirect_ready = 1'b1;
        i_mem_valid = 1'b1; i_mem_eret = 1'b1; i_mem_pc = 32'h8000_5000;
        i_epc = 32'h8000_3000; i_cp0_we = 1'b1; i_cp0_waddr = CP0_ADDR_EPC; i_cp0_wdata = 32'h8000_4000;
        // ERET leaves the exception pc/bd outputs at the previous interrupt's values.
        exp_q.push_back('{EXC_CAUSE_NOP, 32'h8000_2004, 1'b1, 1'b1, 32'h8000_4000});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret} !== {e.cause, e.pc, e.bd, e.eret})
            $display("FAIL eret_commit: got cause=%h pc=%h bd=%b eret=%b want %h %h %b %b",
                     o_except_cause, o_exc_pc, o_exc_bd, o_is_eret, e.cause, e.pc, e.bd, e.eret);
        else n_pass++;
        step();
        n_checks++;
        if (o_is_eret !== 1'b0 || o_flush !== 1'b1) $display("FAIL eret_pulse: eret=%b flush=%b want 0 1", o_is_eret, o_flush);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || o_redirect_pc !== e.tgt) $display("FAIL eret_target: seen=%b rpc=%h want %h", seen, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
        // Exception and ERET in the same cycle: exception wins.
        i_mem_valid = 1'b1; i_mem_eret = 1'b1; i_mem_pc = 32'h8000_5004;
        i_ex_cause = EXC_CAUSE_OV; i_ex_pc = 32'h8000_6000; i_ex_bd = 1'b0;
        exp_q.push_back('{EXC_CAUSE_OV, 32'h8000_6000, 1'b0, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret} !== {e.cause, e.pc, e.bd, e.eret})
            $display("FAIL exc_beats_eret: got cause=%h pc=%h eret=%b want %h %h 0",
                     o_except_cause, o_exc_pc, o_is_eret, e.cause, e.pc);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || o_redirect_pc !== e.tgt) $display("FAIL exc_beats_eret_target: seen=%b rpc=%h want %h", seen, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
    endtask

    task automatic test_bev();
        int fc; bit seen;
        i_status = 32'h0040_0000; i_redirect_ready = 1'b1;
        i_if_cause = EXC_CAUSE_ADEL; i_if_pc = 32'hBFC0_0010; i_if_bd = 1'b0;
        exp_q.push_back('{EXC_CAUSE_ADEL, 32'hBFC0_0010, 1'b0, 1'b0, EXC_VECTOR_BEV});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd} !== {e.cause, e.pc, e.bd})
            $display("FAIL bev_commit: got cause=%h pc=%h bd=%b want %h %h %b", o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || o_redirect_pc !== e.tgt) $display("FAIL bev_target: seen=%b rpc=%h want %h", seen, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
        i_status = 32'h0;
    endtask

    task automatic test_stall();
        int fc; bit seen;
        i_redirect_ready = 1'b0;
        i_id_cause = EXC_CAUSE_RI; i_id_pc = 32'h8000_7000; i_id_bd = 1'b1;
        exp_q.push_back('{EXC_CAUSE_RI, 32'h8000_7000, 1'b1, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd} !== {e.cause, e.pc, e.bd})
            $display("FAIL stall_commit: got cause=%h pc=%h bd=%b want %h %h %b", o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        wait_redirect(10, fc, seen);
        for (int i = 0; i < 5; i++) begin
            i_ex_cause = EXC_CAUSE_SYSCALL; i_ex_pc = 32'h8000_8000 + 32'(4 * i);
            i_mem_valid = 1'b1; i_mem_eret = 1'b1;
            step();
            n_checks++;
            if (!seen || o_redirect_valid !== 1'b1 || o_redirect_pc !== e.tgt || o_busy !== 1'b1 ||
                o_except_cause !== EXC_CAUSE_NOP || o_is_eret !== 1'b0)
                $display("FAIL stall_hold[%0d]: rv=%b rpc=%h busy=%b cause=%h eret=%b want 1 %h 1 %h 0",
                         i, o_redirect_valid, o_redirect_pc, o_busy, o_except_cause, o_is_eret, e.tgt, EXC_CAUSE_NOP);
            else n_pass++;
        end
        clear_inputs();
        i_redirect_ready = 1'b1;
        step();
        n_checks++;
        if (o_redirect_valid !== 1'b0 || o_busy !== 1'b0) $display("FAIL stall_release: rv=%b busy=%b want 0 0", o_redirect_valid, o_busy);
        else n_pass++;
        repeat (2) step();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL stall_no_replay: busy=%b want 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int fc; bit seen; bit any_rv;
        i_redirect_ready = 1'b1;
        i_ex_cause = EXC_CAUSE_BP; i_ex_pc = 32'h8000_9000; i_ex_bd = 1'b1;
        exp_q.push_back('{EXC_CAUSE_BP, 32'h8000_9000, 1'b1, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd} !== {e.cause, e.pc, e.bd})
            $display("FAIL rstmid_commit: got cause=%h pc=%h bd=%b want %h %h %b", o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        step();
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd, o_is_eret, o_flush, o_redirect_valid, o_redirect_pc, o_busy} !==
            {EXC_CAUSE_NOP, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0})
            $display("FAIL rstmid_outputs: cause=%h pc=%h bd=%b flush=%b rv=%b rpc=%h busy=%b",
                     o_except_cause, o_exc_pc, o_exc_bd, o_flush, o_redirect_valid, o_redirect_pc, o_busy);
        else n_pass++;
        step();
        resetn = 1'b1;
        any_rv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_redirect_valid !== 1'b0 || o_busy !== 1'b0) any_rv = 1'b1;
        end
        n_checks++;
        if (any_rv) $display("FAIL rstmid_no_redirect: activity after reset, want rv=0 busy=0");
        else n_pass++;
        i_ex_cause = EXC_CAUSE_SYSCALL; i_ex_pc = 32'h8000_A000; i_ex_bd = 1'b0;
        exp_q.push_back('{EXC_CAUSE_SYSCALL, 32'h8000_A000, 1'b0, 1'b0, EXC_VECTOR});
        step();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++;
        if ({o_except_cause, o_exc_pc, o_exc_bd} !== {e.cause, e.pc, e.bd})
            $display("FAIL rstmid_after_commit: got cause=%h pc=%h bd=%b want %h %h %b", o_except_cause, o_exc_pc, o_exc_bd, e.cause, e.pc, e.bd);
        else n_pass++;
        wait_redirect(10, fc, seen);
        n_checks++;
        if (!seen || fc != 2 || o_redirect_pc !== e.tgt)
            $display("FAIL rstmid_after_redirect: seen=%b flush_cycles=%0d rpc=%h want 1 2 %h", seen, fc, o_redirect_pc, e.tgt);
        else n_pass++;
        step();
    endtask

    initial begin
        clear_inputs();
        i_status = 32'h0; i_epc = 32'h0; i_redirect_ready = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_syscall();
        test_int_exl_latency();
        test_int_vs_id();
        test_eret();
        test_bev();
        test_stall();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
